// File: rtl/izh_synapse.sv
// izh_synapse: spike-edge triggered synapse with axonal delay line and decaying saturating current.
module izh_synapse #(
  parameter int WIDTH     = 20,
  parameter int FR_WIDTH  = 11,
  parameter int DELAY     = 4,
  parameter int TAU_SHIFT = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spike_in,
  input  logic signed [WIDTH-1:0]     weight,
  output logic signed [WIDTH-1:0]     isyn,
  output logic        [CNT_WIDTH-1:0] spike_count,
  output logic                        sat
);
  localparam logic signed [WIDTH+1:0] max_v = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] min_v = {3'b111, {(WIDTH-1){1'b0}}};
  if (DELAY < 1 || DELAY > 16 || FR_WIDTH >= WIDTH) begin : g_bad_params
    $error("izh_synapse: illegal parameter set");
  end
  logic                         spike_prev, rise;
  logic [DELAY-1:0]             vld;
  logic [DELAY-1:0][WIDTH-1:0]  wgt;
  logic signed [WIDTH-1:0]      d, dec;
  logic signed [WIDTH+1:0]      sum, arr;
  logic                         clip_hi, clip_lo;
  always_comb begin
    rise = spike_in & ~spike_prev;
    d = isyn >>> TAU_SHIFT;
    // floor shift never brings small positives to zero, so force a unit step
    dec = (d == '0 && isyn > 0) ? {{(WIDTH-1){1'b0}}, 1'b1} : d;
    arr = vld[DELAY-1] ? {{2{wgt[DELAY-1][WIDTH-1]}}, wgt[DELAY-1]} : '0;
    sum = {{2{isyn[WIDTH-1]}}, isyn} - {{2{dec[WIDTH-1]}}, dec} + arr;
    clip_hi = sum > max_v;
    clip_lo = sum < min_v;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_prev  <= 1'b0;
      vld         <= '0;
      wgt         <= '0;
      isyn        <= '0;
      spike_count <= '0;
      sat         <= 1'b0;
    end else begin
      spike_prev <= spike_in;
      for (int i = DELAY - 1; i > 0; i--) begin
        vld[i] <= vld[i-1];
        wgt[i] <= wgt[i-1];
      end
      vld[0]      <= rise;
      wgt[0]      <= rise ? weight : '0;
      isyn        <= clip_hi ? max_v[WIDTH-1:0] : clip_lo ? min_v[WIDTH-1:0] : sum[WIDTH-1:0];
      sat         <= clip_hi | clip_lo;
      spike_count <= spike_count + CNT_WIDTH'(rise);
    end
  end
endmodule

// File: tb/tb_izh_synapse.sv
// tb_izh_synapse: table-driven directed checks of izh_synapse plus multi-cycle corner sequences.
module tb_izh_synapse;
  logic               clk = 1'b0;
  logic               reset = 1'b1, spike_in = 1'b0;
  logic signed [19:0] weight = '0;
  logic signed [19:0] isyn, isyn_w;
  logic [15:0]        spike_count;
  logic [7:0]         cnt_w;
  logic               sat, sat_w;
  int checks = 0, errors = 0;

  typedef struct {
    logic rst;
    logic spk;
    int   w;
    int   isyn;
    int   cnt;
    logic sat;
  } vec_t;
  vec_t tbl[$];

  izh_synapse dut (
    .clk(clk), .reset(reset), .spike_in(spike_in), .weight(weight),
    .isyn(isyn), .spike_count(spike_count), .sat(sat)
  );
  // narrow counter instance so counter wrap fits in a short run
  izh_synapse #(.CNT_WIDTH(8)) dut_w (
    .clk(clk), .reset(reset), .spike_in(spike_in), .weight(weight),
    .isyn(isyn_w), .spike_count(cnt_w), .sat(sat_w)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic s, input int w, input int i,
                              input int c, input logic st);
    vec_t v;
    v.rst = r; v.spk = s; v.w = w; v.isyn = i; v.cnt = c; v.sat = st;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input int w);
    reset = r;
    spike_in = s;
    weight = 20'(w);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sp[7] = '{5, 4, 3, 2, 1, 0, 0};
    add(1, 0, 0, 0, 0, 0);
    // single spike timing and decay
    add(0, 1, 16384, 0, 1, 0);
    repeat (3) add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 16384, 1, 0);
    add(0, 0, 0, 15360, 1, 0);
    add(0, 0, 0, 14400, 1, 0);
    add(1, 0, 0, 0, 0, 0);
    // small-value convergence, positive then negative
    add(0, 1, 5, 0, 1, 0);
    repeat (3) add(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 7; k++) add(0, 0, 0, sp[k], 1, 0);
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, -5, 0, 1, 0);
    repeat (3) add(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 7; k++) add(0, 0, 0, -sp[k], 1, 0);
    add(1, 0, 0, 0, 0, 0);
    // positive saturation with edges every second cycle
    add(0, 1, 524287, 0, 1, 0);
    add(0, 0, 524287, 0, 1, 0);
    add(0, 1, 524287, 0, 2, 0);
    add(0, 0, 524287, 0, 2, 0);
    add(0, 1, 524287, 524287, 3, 0);
    add(0, 0, 0, 491520, 3, 0);
    add(0, 0, 0, 524287, 3, 1);
    add(0, 0, 0, 491520, 3, 0);
    add(0, 0, 0, 524287, 3, 1);
    add(0, 0, 0, 491520, 3, 0);
    add(1, 0, 0, 0, 0, 0);
    // negative full-scale arrival and decay toward zero
    add(0, 1, -524288, 0, 1, 0);
    repeat (3) add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, -524288, 1, 0);
    add(0, 0, 0, -491520, 1, 0);
    add(0, 0, 0, -460800, 1, 0);
    add(1, 0, 0, 0, 0, 0);
    // weight change after capture does not affect in-flight spike
    add(0, 1, 2048, 0, 1, 0);
    repeat (3) add(0, 0, -2048, 0, 1, 0);
    add(0, 0, -2048, 2048, 1, 0);
    add(0, 0, -2048, 1920, 1, 0);
    add(1, 0, 0, 0, 0, 0);
    // reset mid-flight, with an edge coincident with reset
    add(0, 1, 4096, 0, 1, 0);
    add(0, 0, 4096, 0, 1, 0);
    add(1, 1, 4096, 0, 0, 0);
    repeat (8) add(0, 0, 4096, 0, 0, 0);
    // spike held high through reset deassertion counts once
    add(1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].spk, tbl[k].w);
      chk($sformatf("v%0d isyn", k), isyn, tbl[k].isyn);
      chk($sformatf("v%0d count", k), int'(spike_count), tbl[k].cnt);
      chk($sformatf("v%0d sat", k), int'(sat), int'(tbl[k].sat));
    end

    // held level: one contribution, then a fresh edge after a low cycle
    for (int e = 0; e < 10; e++) begin
      step(0, 1, 2048);
      chk($sformatf("held e%0d count", e), int'(spike_count), 1);
      if (e == 4) chk("held arrival", isyn, 2048);
      if (e == 9) chk("held decay", isyn, 1485);
    end
    step(0, 0, 2048);
    chk("held low isyn", isyn, 1393);
    step(0, 1, 2048);
    chk("held re-edge count", int'(spike_count), 2);
    chk("held re-edge isyn", isyn, 1306);
    repeat (3) step(0, 1, 2048);
    step(0, 1, 2048);
    chk("held second arrival", isyn, 3059);
    chk("held final count", int'(spike_count), 2);

    // counter wrap on the 8-bit instance
    step(1, 0, 0);
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 1);
      step(0, 0, 1);
      if (i == 254) chk("wrap pre", int'(cnt_w), 255);
    end
    chk("wrap narrow", int'(cnt_w), 0);
    chk("wrap wide", int'(spike_count), 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
